sync_fifo_prog: RTL and testbench

- Single-clock FIFO with programmable almost-full/almost-empty thresholds, a fill-level output, and sticky error flags.
- Read mode is selectable: standard (registered, 1-cycle read latency) or first-word-fall-through (FWFT).
- Used as the general buffering primitive wherever producer and consumer share one clock.
- Keeps the full/overflow/empty/underflow flag set of the existing async FIFO, so benches can reuse stimulus tasks.

---
 rtl/sync_fifo_prog_pkg.sv | 14 +
 rtl/sync_fifo_prog_if.sv | 46 ++++
 rtl/sync_fifo_prog_mem.sv | 27 ++
 rtl/sync_fifo_prog.sv | 136 +++++++++++++
 tb/tb_sync_fifo_prog.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_prog_pkg.sv
// Shared definitions for the programmable-threshold synchronous FIFO:
// fill-level width helper and the read-mode selector constants.
package fifo_pkg;

  // Read-mode selector values for the FWFT parameter.
  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Width of a fill level able to hold 0..depth inclusive (PTR_WIDTH+1).
  function automatic int fill_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Bus bundle between a FIFO user (master) and the FIFO (slave).
//
// Handshake: a write is taken on a rising edge where wr_en=1 and the FIFO
// has room (or a read is taken on the same edge); a read is taken where
// rd_en=1 and the FIFO is not empty. Rejected requests are reported by the
// one-cycle overflow/underflow pulses rather than by stalling. r_valid marks
// r_data as holding a word.
interface sync_fifo_prog_if #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8
);
  import fifo_pkg::*;

  localparam int CW = fill_width(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic [CW-1:0]         af_thresh;
  logic [CW-1:0]         ae_thresh;
  logic                  overflow;
  logic                  underflow;
  logic                  err_clr;
  logic                  ovf_sticky;
  logic                  udf_sticky;

  modport master (
    output wr_en, w_data, rd_en, af_thresh, ae_thresh, err_clr,
    input  r_data, r_valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow, ovf_sticky, udf_sticky
  );

  modport slave (
    input  wr_en, w_data, rd_en, af_thresh, ae_thresh, err_clr,
    output r_data, r_valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow, ovf_sticky, udf_sticky
  );

endinterface

// File: rtl/sync_fifo_prog_mem.sv
// Flop-based dual-port storage: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module fifo_mem_2p #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Store the write word at the write address on each enabled edge.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// fill level, one-cycle overflow/underflow pulses and sticky error flags.
// FWFT selects registered (1-cycle latency) or first-word-fall-through reads.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = FIFO_STD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sync_fifo_prog_if.slave      bus
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int CW        = PTR_WIDTH + 1;

  logic [CW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  r_ovf_sticky;
  logic                  r_udf_sticky;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_ovf_evt;
  logic                  w_udf_evt;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  // The pointer MSB is a wrap bit: equal addresses with differing wrap bits
  // means the writer is a full lap ahead.
  assign w_full  = (r_wr_ptr[PTR_WIDTH-1:0] == r_rd_ptr[PTR_WIDTH-1:0]) &&
                   (r_wr_ptr[PTR_WIDTH] != r_rd_ptr[PTR_WIDTH]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // A same-cycle write never feeds a read of an empty FIFO, but a same-cycle
  // read frees the slot a write into a full FIFO needs.
  assign w_rd_acc  = bus.rd_en && !w_empty;
  assign w_wr_acc  = bus.wr_en && (!w_full || w_rd_acc);
  assign w_ovf_evt = bus.wr_en && !w_wr_acc;
  assign w_udf_evt = bus.rd_en && w_empty;

  fifo_mem_2p #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[PTR_WIDTH-1:0]),
    .i_wdata (bus.w_data),
    .i_raddr (r_rd_ptr[PTR_WIDTH-1:0]),
    .o_rdata (w_mem_rdata)
  );

  // Advance the pointers on accepted transfers; they wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + CW'(1);
    end
  end

  // Track the fill level: up on write only, down on read only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // One-cycle rejection pulses plus sticky copies; a new event beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_udf_sticky <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_evt;
      r_underflow <= w_udf_evt;
      if (w_ovf_evt)        r_ovf_sticky <= 1'b1;
      else if (bus.err_clr) r_ovf_sticky <= 1'b0;
      if (w_udf_evt)        r_udf_sticky <= 1'b1;
      else if (bus.err_clr) r_udf_sticky <= 1'b0;
    end
  end

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      // The head word is always presented; rd_en only pops it.
      assign bus.r_data  = w_mem_rdata;
      assign bus.r_valid = !w_empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_rdata;
      logic                  r_rvalid;

      // Capture the head on an accepted read; hold it until the next one.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rdata  <= '0;
          r_rvalid <= 1'b0;
        end else begin
          r_rvalid <= w_rd_acc;
          if (w_rd_acc) r_rdata <= w_mem_rdata;
        end
      end

      assign bus.r_data  = r_rdata;
      assign bus.r_valid = r_rvalid;
    end
  endgenerate

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.count        = r_count;
  assign bus.almost_full  = (r_count >= bus.af_thresh);
  assign bus.almost_empty = (r_count <= bus.ae_thresh);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
  assign bus.ovf_sticky   = r_ovf_sticky;
  assign bus.udf_sticky   = r_udf_sticky;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: one standard-mode and one FWFT instance, driven
// by directed and random stimulus, checked against queue-based models.
module tb_sync_fifo_prog;

  localparam int DEPTH = 16;
  localparam int DW    = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sync_fifo_prog_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) if_s ();
  sync_fifo_prog_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) if_f ();

  sync_fifo_prog #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(0)) u_std (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_s.slave)
  );

  sync_fifo_prog #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1)) u_fwft (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_f.slave)
  );

  // ---------------- reference model state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int af_v  = 14;
  int ae_v  = 2;

  logic [DW-1:0] mq_s[$];    // standard FIFO contents
  logic [DW-1:0] exp_q[$];   // expected standard read words, in order
  logic [DW-1:0] fq[$];      // FWFT FIFO contents (head = expected r_data)
  logic [DW-1:0] last_s = '0;
  logic os_s = 0, us_s = 0, os_f = 0, us_f = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_flags(input string tag, input logic [4:0] cnt,
                             input logic full, input logic empty,
                             input logic af, input logic ae,
                             input logic ovf, input logic udf,
                             input logic os, input logic us,
                             input int sz, input logic eovf, input logic eudf,
                             input logic eos, input logic eus);
    chk({tag, ".count"},        32'(cnt),   32'(sz));
    chk({tag, ".full"},         32'(full),  32'(sz == DEPTH));
    chk({tag, ".empty"},        32'(empty), 32'(sz == 0));
    chk({tag, ".almost_full"},  32'(af),    32'(sz >= af_v));
    chk({tag, ".almost_empty"}, 32'(ae),    32'(sz <= ae_v));
    chk({tag, ".overflow"},     32'(ovf),   32'(eovf));
    chk({tag, ".underflow"},    32'(udf),   32'(eudf));
    chk({tag, ".ovf_sticky"},   32'(os),    32'(eos));
    chk({tag, ".udf_sticky"},   32'(us),    32'(eus));
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic step_s(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
    logic rd_ok, wr_ok, e_ovf, e_udf;
    if_s.wr_en = wr; if_s.w_data = d; if_s.rd_en = rd; if_s.err_clr = clr;
    if_s.af_thresh = 5'(af_v); if_s.ae_thresh = 5'(ae_v);
    rd_ok = rd && (mq_s.size() != 0);
    wr_ok = wr && ((mq_s.size() < DEPTH) || rd_ok);
    e_ovf = wr && !wr_ok;
    e_udf = rd && (mq_s.size() == 0);
    if (rd_ok) begin
      last_s = mq_s.pop_front();
      exp_q.push_back(last_s);
    end
    if (wr_ok) mq_s.push_back(d);
    os_s = e_ovf ? 1'b1 : (clr ? 1'b0 : os_s);
    us_s = e_udf ? 1'b1 : (clr ? 1'b0 : us_s);
    @(posedge clk); #1;
    if_s.wr_en = 0; if_s.rd_en = 0; if_s.err_clr = 0;
    check_flags("std", if_s.count, if_s.full, if_s.empty, if_s.almost_full,
                if_s.almost_empty, if_s.overflow, if_s.underflow,
                if_s.ovf_sticky, if_s.udf_sticky,
                mq_s.size(), e_ovf, e_udf, os_s, us_s);
    chk("std.r_data_hold", 32'(if_s.r_data), 32'(last_s));
  endtask

  task automatic step_f(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
    logic rd_ok, wr_ok, e_ovf, e_udf;
    if_f.wr_en = wr; if_f.w_data = d; if_f.rd_en = rd; if_f.err_clr = clr;
    if_f.af_thresh = 5'(af_v); if_f.ae_thresh = 5'(ae_v);
    rd_ok = rd && (fq.size() != 0);
    wr_ok = wr && ((fq.size() < DEPTH) || rd_ok);
    e_ovf = wr && !wr_ok;
    e_udf = rd && (fq.size() == 0);
    os_f = e_ovf ? 1'b1 : (clr ? 1'b0 : os_f);
    us_f = e_udf ? 1'b1 : (clr ? 1'b0 : us_f);
    // the head pop for rd_ok is taken by the FWFT monitor at the negedge
    @(posedge clk); #1;
    if (wr_ok) fq.push_back(d);
    if_f.wr_en = 0; if_f.rd_en = 0; if_f.err_clr = 0;
    check_flags("fwft", if_f.count, if_f.full, if_f.empty, if_f.almost_full,
                if_f.almost_empty, if_f.overflow, if_f.underflow,
                if_f.ovf_sticky, if_f.udf_sticky,
                fq.size(), e_ovf, e_udf, os_f, us_f);
  endtask

  task automatic clear_models();
    mq_s.delete(); exp_q.delete(); fq.delete();
    last_s = '0; os_s = 0; us_s = 0; os_f = 0; us_f = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_models();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  // ---------------- monitors / scoreboard ----------------
  // Standard mode: every r_valid pulse consumes one expected word.
  logic [DW-1:0] mon_e;
  always @(negedge clk) begin
    if (rst_n && if_s.r_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL std.r_valid_unexpected: got r_valid=1 data %0h expected no read (t=%0t)",
                 if_s.r_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("std.r_data", 32'(if_s.r_data), 32'(mon_e));
      end
    end
  end

  // FWFT mode: the head is visible while non-empty; rd_en pops it at the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("fwft.r_valid", 32'(if_f.r_valid), 32'(fq.size() != 0));
      if (if_f.r_valid && (fq.size() != 0)) begin
        chk("fwft.r_data", 32'(if_f.r_data), 32'(fq[0]));
        if (if_f.rd_en) void'(fq.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0;
    if_s.wr_en = 0; if_s.w_data = '0; if_s.rd_en = 0; if_s.err_clr = 0;
    if_f.wr_en = 0; if_f.w_data = '0; if_f.rd_en = 0; if_f.err_clr = 0;
    if_s.af_thresh = 5'd14; if_s.ae_thresh = 5'd2;
    if_f.af_thresh = 5'd14; if_f.ae_thresh = 5'd2;
    repeat (3) @(posedge clk);
    #1;
    // reset values
    check_flags("rst", if_s.count, if_s.full, if_s.empty, if_s.almost_full,
                if_s.almost_empty, if_s.overflow, if_s.underflow,
                if_s.ovf_sticky, if_s.udf_sticky, 0, 0, 0, 0, 0);
    chk("rst.r_valid", 32'(if_s.r_valid), 32'(0));
    chk("rst.r_data",  32'(if_s.r_data),  32'(0));
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // reset mid-fill: must clear immediately, without a clock edge
    for (int i = 0; i < 5; i++) step_s(1, 8'(8'h11 + i), 0, 0);
    step_s(0, 0, 1, 0);
    #2; rst_n = 0; #1;
    chk("midrst.count",   32'(if_s.count),   32'(0));
    chk("midrst.empty",   32'(if_s.empty),   32'(1));
    chk("midrst.r_valid", 32'(if_s.r_valid), 32'(0));
    clear_models();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // full / overflow: 17 writes, last one rejected
    for (int i = 1; i <= 17; i++) step_s(1, 8'(i), 0, 0);
    for (int i = 0; i < 16; i++) step_s(0, 0, 1, 0);
    step_s(0, 0, 0, 0);

    // underflow, err_clr, and set-beats-clear
    do_reset();
    step_s(0, 0, 1, 0);
    step_s(0, 0, 0, 0);
    step_s(0, 0, 0, 1);
    step_s(0, 0, 1, 1);
    step_s(0, 0, 0, 1);

    // simultaneous read+write at full
    for (int i = 1; i <= 16; i++) step_s(1, 8'(i), 0, 0);
    for (int i = 0; i < 4; i++) step_s(1, 8'(8'hA0 + i), 1, 0);
    for (int i = 0; i < 16; i++) step_s(0, 0, 1, 0);
    step_s(0, 0, 0, 0);

    // simultaneous read+write at empty
    step_s(1, 8'h5A, 1, 0);
    step_s(0, 0, 1, 0);
    step_s(0, 0, 0, 0);
    step_s(0, 0, 0, 1);

    // random standard-mode traffic with moving thresholds
    for (int i = 0; i < 200; i++) begin
      if (i % 25 == 0) begin
        af_v = $urandom_range(0, 20);
        ae_v = $urandom_range(0, 17);
      end
      step_s(1'($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 15) == 0));
    end
    af_v = 14; ae_v = 2;
    for (int i = 0; i < 18; i++) step_s(0, 0, 1, 0);
    step_s(0, 0, 0, 0);

    // FWFT: word appears the cycle after the write, no rd_en needed
    step_f(1, 8'h3C, 0, 0);
    chk("fwft.first_word", 32'(if_f.r_data),  32'(8'h3C));
    chk("fwft.first_vld",  32'(if_f.r_valid), 32'(1));
    step_f(0, 0, 1, 0);
    chk("fwft.pop_empty",  32'(if_f.empty),   32'(1));
    step_f(0, 0, 1, 0);
    step_f(0, 0, 0, 1);
    for (int i = 1; i <= 17; i++) step_f(1, 8'(8'hC0 + i), 0, 0);
    step_f(1, 8'hEE, 1, 0);
    for (int i = 0; i < 200; i++) begin
      if (i % 25 == 0) begin
        af_v = $urandom_range(0, 20);
        ae_v = $urandom_range(0, 17);
      end
      step_f(1'($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 15) == 0));
    end
    step_f(0, 0, 0, 0);

    // every expected standard read must have been observed
    chk("std.reads_outstanding", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
